// File: rtl/riscv_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package riscv_pkg;

  localparam int LOADER_LEN_W = 16;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs four accepted bytes into one little-endian 32-bit word; word_vld is
// asserted combinationally alongside the fourth byte so the caller can register it.
module word_assembler (
  input  logic        clk,
  input  logic        srst,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] lanes_q, lanes_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    word_vld   = 1'b0;
    if (byte_vld) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    lanes_d[7:0]   = byte_in;
        2'd1:    lanes_d[15:8]  = byte_in;
        2'd2:    lanes_d[23:16] = byte_in;
        default: word_vld       = 1'b1;
      endcase
    end
  end

  // The top lane is taken straight from the incoming byte.
  assign word = {byte_in, lanes_q};

  always_ff @(posedge clk) begin
    if (srst) begin
      byte_idx_q <= 2'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    lanes_q <= lanes_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory
// and keeps the core in reset until the image has been accepted as good.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_srst,
  output logic        done,
  output logic        error
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [LOADER_LEN_W-1:0] MAX_LEN = LOADER_LEN_W'(DEPTH);

  loader_state_e             state_q, state_d;
  logic [LOADER_LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
  logic [7:0]                csum_q, csum_d;
  logic                      rx_ready_q, rx_ready_d;
  logic                      imem_we_q, imem_we_d;
  logic [31:0]               imem_addr_q, imem_addr_d;
  logic [31:0]               imem_wd_q, imem_wd_d;
  logic                      core_srst_q, core_srst_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  logic                      accept;
  logic                      word_vld;
  logic [31:0]               word;

  assign accept = rx_valid && rx_ready_q;

  word_assembler u_word_assembler (
    .clk      (clk),
    .srst     (srst),
    .byte_vld (accept && (state_q == S_DATA)),
    .byte_in  (rx_data),
    .word_vld (word_vld),
    .word     (word)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    csum_d      = csum_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_wd_d   = imem_wd_q;

    case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          if ((len_d == '0) || (len_d > MAX_LEN)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
        end
        if (word_vld) begin
          imem_we_d   = 1'b1;
          imem_addr_d = BASE_ADDR + (32'(word_cnt_q) << 2);
          imem_wd_d   = word;
          word_cnt_d  = word_cnt_q + CNT_W'(1);
          if (LOADER_LEN_W'(word_cnt_d) == len_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: ;
    endcase

    // Status flags follow the next state so they all move on the same edge.
    rx_ready_d  = state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    core_srst_d = !done_d;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_LEN0;
      word_cnt_q  <= '0;
      csum_q      <= '0;
      rx_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= BASE_ADDR;
      imem_wd_q   <= '0;
      core_srst_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      csum_q      <= csum_d;
      rx_ready_q  <= rx_ready_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_wd_q   <= imem_wd_d;
      core_srst_q <= core_srst_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q <= len_d;
  end

  assign rx_ready  = rx_ready_q;
  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wd   = imem_wd_q;
  assign core_srst = core_srst_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 0x0 and 0x100) share one
// stimulus stream and are compared every cycle against a stream-level model.
module tb_imem_loader;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic        rx_ready0, imem_we0, core_srst0, done0, error0;
  logic [31:0] imem_addr0, imem_wd0;
  logic        rx_ready1, imem_we1, core_srst1, done1, error1;
  logic [31:0] imem_addr1, imem_wd1;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .srst(srst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0),
    .imem_wd(imem_wd0), .core_srst(core_srst0), .done(done0), .error(error0)
  );

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0100)) dut1 (
    .clk(clk), .srst(srst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1),
    .imem_wd(imem_wd1), .core_srst(core_srst1), .done(done1), .error(error1)
  );

  int checks = 0;
  int errors = 0;

  // Stream-level reference: position k of accepted bytes decides their meaning.
  typedef struct packed {
    int          k;
    logic [15:0] len;
    logic [7:0]  csum;
    logic [31:0] wbuf;
    logic        ready;
    logic        we;
    logic [15:0] widx;
    logic [31:0] wd;
    logic        done;
    logic        err;
  } mdl_t;

  mdl_t m;
  logic m_started = 1'b0;

  function automatic mdl_t model_step(mdl_t s, logic rst, logic v, logic [7:0] b);
    mdl_t n;
    int p;
    n = s;
    n.we = 1'b0;
    if (rst) begin
      n = '0;
      return n;
    end
    if (s.ready && v) begin
      n.k = s.k + 1;
      if (n.k == 1) begin
        n.len[7:0] = b;
      end else if (n.k == 2) begin
        n.len[15:8] = b;
        if (n.len == 16'd0 || n.len > 16'(DEPTH)) n.err = 1'b1;
      end else if (n.k <= 2 + 4 * int'(s.len)) begin
        p = n.k - 3;
        n.wbuf[8*(p%4) +: 8] = b;
        n.csum = s.csum ^ b;
        if (p % 4 == 3) begin
          n.we   = 1'b1;
          n.widx = 16'(p / 4);
          n.wd   = n.wbuf;
        end
      end else begin
        if (b == s.csum) n.done = 1'b1;
        else             n.err  = 1'b1;
      end
    end
    n.ready = !n.done && !n.err;
    return n;
  endfunction

  function automatic logic [68:0] exp_vec(logic [31:0] base);
    return {m.ready, m.we, ~m.done, m.done, m.err,
            base + {14'b0, m.widx, 2'b00}, m.wd};
  endfunction

  always @(posedge clk) begin
    m         <= model_step(m, srst, rx_valid, rx_data);
    m_started <= 1'b1;
  end

  task automatic check_vec(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got {rdy,we,csrst,done,err,addr,wd}=%h expected %h",
               name, $time, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];

  always @(negedge clk) begin
    if (m_started) begin
      check_vec("cycle_base0",
                {rx_ready0, imem_we0, core_srst0, done0, error0, imem_addr0, imem_wd0},
                exp_vec(32'h0000_0000));
      check_vec("cycle_base100",
                {rx_ready1, imem_we1, core_srst1, done1, error1, imem_addr1, imem_wd1},
                exp_vec(32'h0000_0100));
      if (imem_we0) begin qa0.push_back(imem_addr0); qd0.push_back(imem_wd0); end
      if (imem_we1) begin qa1.push_back(imem_addr1); qd1.push_back(imem_wd1); end
    end
  end

  logic [31:0] words [0:127];

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit acc;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      acc = rx_ready0;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %h got rx_ready=0 expected rx_ready=1", b);
    end
  endtask

  // mode 0: correct checksum, 1: send ov literally, 2: send inverted checksum
  task automatic send_image(input int n, input logic [15:0] len, input int mode,
                            input logic [7:0] ov, input int gap);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < 4; l++) begin
        b  = words[i][8*l +: 8];
        cs = cs ^ b;
        send_byte(b, gap);
      end
    end
    if (n > 0) begin
      if (mode == 1)      send_byte(ov, gap);
      else if (mode == 2) send_byte(~cs, gap);
      else                send_byte(cs, gap);
    end
  endtask

  task automatic clear_queues();
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
  endtask

  task automatic do_reset();
    srst     = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check32("rst_rx_ready", 32'(rx_ready0), 32'd0);
    check32("rst_core_srst", 32'(core_srst0), 32'd1);
    check32("rst_done_error", {30'd0, done1, error1}, 32'd0);
    check32("rst_addr_base100", imem_addr1, 32'h0000_0100);
    check32("rst_wd", imem_wd0, 32'd0);
    clear_queues();
    srst = 1'b0;
  endtask

  task automatic finish_check(input string name, input bit good);
    repeat (3) @(negedge clk);
    check32({name, "_done"}, 32'(done0), 32'(good));
    check32({name, "_error"}, 32'(error1), 32'(!good));
    check32({name, "_core_srst"}, 32'(core_srst0), 32'(!good));
    check32({name, "_rx_ready"}, 32'(rx_ready1), 32'd0);
  endtask

  initial begin
    int n;
    int mode;
    repeat (3) @(negedge clk);
    do_reset();

    // Normal N=2 image; checksum 13^50^93^A0 = 0x70
    words[0] = 32'h0050_0013;
    words[1] = 32'h00A0_0093;
    send_image(2, 16'd2, 1, 8'h70, 0);
    finish_check("normal", 1'b1);
    check32("normal_nwr", qa0.size(), 32'd2);
    check32("normal_a0", qa0[0], 32'h0);
    check32("normal_d0", qd0[0], 32'h0050_0013);
    check32("normal_a1", qa0[1], 32'h4);
    check32("normal_d1", qd0[1], 32'h00A0_0093);
    check32("normal_b1_a1", qa1[1], 32'h104);

    do_reset();
    send_image(2, 16'd2, 1, 8'hFF, 0);
    finish_check("badcsum", 1'b0);
    check32("badcsum_nwr", qa0.size(), 32'd2);

    do_reset();
    send_image(0, 16'd0, 0, 8'h00, 0);
    finish_check("len0", 1'b0);
    check32("len0_nwr", qa0.size(), 32'd0);

    do_reset();
    send_image(0, 16'd65, 0, 8'h00, 0);
    finish_check("len65", 1'b0);
    check32("len65_nwr", qa0.size(), 32'd0);

    do_reset();
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    send_image(64, 16'd64, 0, 8'h00, 0);
    finish_check("len64", 1'b1);
    check32("len64_nwr", qa0.size(), 32'd64);
    check32("len64_last_a", qa0[63], 32'h0000_00FC);
    check32("len64_last_d", qd0[63], words[63]);
    check32("len64_b1_last_a", qa1[63], 32'h0000_01FC);

    // Same image as the normal run, with idle gaps and late bytes after done
    do_reset();
    words[0] = 32'h0050_0013;
    words[1] = 32'h00A0_0093;
    send_image(2, 16'd2, 0, 8'h00, 5);
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    finish_check("gaps", 1'b1);
    check32("gaps_nwr", qa0.size(), 32'd2);
    check32("gaps_d0", qd0[0], 32'h0050_0013);
    check32("gaps_a1", qa0[1], 32'h4);
    check32("gaps_d1", qd0[1], 32'h00A0_0093);

    // Reset after the 6th payload byte, colliding with a valid byte
    do_reset();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    srst     = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    @(negedge clk);
    rx_valid = 1'b0;
    clear_queues();
    srst = 1'b0;
    words[0] = 32'h0000_0137;
    send_image(1, 16'd1, 1, 8'h36, 0);
    finish_check("midrst", 1'b1);
    check32("midrst_nwr", qa0.size(), 32'd1);
    check32("midrst_a0", qa0[0], 32'h0);
    check32("midrst_d0", qd0[0], 32'h0000_0137);

    do_reset();
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    send_image(3, 16'd3, 0, 8'h00, 2);
    finish_check("base100", 1'b1);
    check32("base100_a0", qa1[0], 32'h100);
    check32("base100_a1", qa1[1], 32'h104);
    check32("base100_a2", qa1[2], 32'h108);
    check32("base100_d2", qd1[2], words[2]);

    for (int r = 0; r < 12; r++) begin
      do_reset();
      n    = int'($urandom_range(8, 1));
      mode = ($urandom_range(2, 0) == 0) ? 2 : 0;
      for (int i = 0; i < n; i++) words[i] = $urandom;
      send_image(n, 16'(n), mode, 8'h00, int'($urandom_range(3, 0)));
      finish_check("rand", mode == 0);
      check32("rand_nwr", qa0.size(), 32'(n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
